// File: rtl/upc_entry_pkg.sv
// Shared UPC definitions for the entry front-end and the display/decoder stage:
// code constants, FSM state type, frame layout and the code validity check.
package upc_pkg;

    localparam logic [2:0] UPC_BALL  = 3'b000;
    localparam logic [2:0] UPC_CROCS = 3'b001;
    localparam logic [2:0] UPC_IGLOO = 3'b010;
    localparam logic [2:0] UPC_DRESS = 3'b101;
    localparam logic [2:0] UPC_CHESS = 3'b110;
    localparam logic [2:0] UPC_GOLD  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } upc_state_e;

    typedef struct packed {
        logic [2:0] upc;
        logic       mark;
    } upc_frame_t;

    function automatic logic upc_is_valid(input logic [2:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            UPC_BALL, UPC_CROCS, UPC_IGLOO,
            UPC_DRESS, UPC_CHESS, UPC_GOLD: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/upc_entry_if.sv
// Entry-side bundle: raw key/switch inputs and the held code/mark plus status.
interface upc_entry_if;
    logic       key_in;
    logic       bit_in;
    logic [2:0] upc;
    logic       mark;
    logic       valid;
    logic       load;
    logic       err;
    logic       busy;
    logic [1:0] bit_cnt;

    modport slave (
        input  key_in, bit_in,
        output upc, mark, valid, load, err, busy, bit_cnt
    );

    modport master (
        output key_in, bit_in,
        input  upc, mark, valid, load, err, busy, bit_cnt
    );
endinterface

// File: rtl/upc_entry_key_edge.sv
// Key synchroniser (resets to the released level) with a registered
// single-cycle falling-edge pulse.
module key_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_press
);
    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_live;
    logic              r_prev;
    logic              r_press;

    // r_live marks when the synchroniser holds real samples rather than its
    // reset value, so a key held down through reset never counts as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '1;
            r_live  <= '0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[STAGES-2:0], i_key};
            r_live  <= {r_live[STAGES-2:0], 1'b1};
            r_prev  <= r_sync[STAGES-1] & r_live[STAGES-1];
            r_press <= r_prev & ~r_sync[STAGES-1];
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/upc_entry.sv
// UPC entry: shifts a 4-bit frame (upc[2:0] then mark) in from key presses,
// validates it and holds the accepted code. Optional stall timeout: UPC_ENTRY_TIMEOUT_EN.
module upc_entry
    import upc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic        clk,
    input logic        reset,
    upc_entry_if.slave bus
);
    logic       w_press;
    logic       w_bit;
    logic       w_expire;
    upc_frame_t w_frame;

    logic [1:0] r_bit_sync;
    logic [2:0] r_shift;
    upc_state_e r_state;
    logic [1:0] r_bit_cnt;
    logic [2:0] r_upc;
    logic       r_mark;
    logic       r_valid;
    logic       r_load;
    logic       r_err;

    key_edge #(.STAGES(2)) u_key_edge (
        .clk     (clk),
        .reset   (reset),
        .i_key   (bus.key_in),
        .o_press (w_press)
    );

    always_ff @(posedge clk) begin
        if (reset) r_bit_sync <= 2'b00;
        else       r_bit_sync <= {r_bit_sync[0], bus.bit_in};
    end

    assign w_bit   = r_bit_sync[1];
    // The three earlier bits live in r_shift; the 4th arrives with the press.
    assign w_frame = {r_shift, w_bit};

`ifdef UPC_ENTRY_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (reset || w_press || r_state == IDLE) r_timer <= '0;
        else                                     r_timer <= r_timer + 1'b1;
    end

    assign w_expire = (r_state == SHIFT) && !w_press &&
                      (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_upc     <= UPC_BALL;
            r_mark    <= 1'b0;
            r_valid   <= 1'b0;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_err  <= 1'b0;
            if (w_press) begin
                r_shift <= w_frame[2:0];
                if (r_state == IDLE) begin
                    r_state   <= SHIFT;
                    r_bit_cnt <= 2'd1;
                end else if (r_bit_cnt == 2'd3) begin
                    r_state   <= IDLE;
                    r_bit_cnt <= 2'd0;
                    if (upc_is_valid(w_frame.upc)) begin
                        r_upc   <= w_frame.upc;
                        r_mark  <= w_frame.mark;
                        r_valid <= 1'b1;
                        r_load  <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 2'd1;
                end
            end else if (w_expire) begin
                r_state   <= IDLE;
                r_bit_cnt <= 2'd0;
                r_err     <= 1'b1;
            end
        end
    end

    assign bus.upc     = r_upc;
    assign bus.mark    = r_mark;
    assign bus.valid   = r_valid;
    assign bus.load    = r_load;
    assign bus.err     = r_err;
    assign bus.busy    = (r_state == SHIFT);
    assign bus.bit_cnt = r_bit_cnt;
endmodule

// File: tb/tb_upc_entry.sv
// Directed bench for upc_entry: reset behaviour, frame latency, a table of
// frames, reset mid-frame, held key, back-to-back frames and optional timeout.
module tb_upc_entry;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    upc_entry_if bus();

    upc_entry #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int load_cycles = 0;
    int err_cycles = 0;

    // Pulses visible after edge K are counted at edge K+1.
    always @(posedge clk) begin
        if (bus.load === 1'b1) load_cycles++;
        if (bus.err === 1'b1)  err_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] bits;
        logic [2:0] exp_upc;
        logic       exp_mark;
        logic       exp_valid;
        int         exp_loads;
        int         exp_errs;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Spec-compliant press: bit stable 2 cycles before the fall through N+3.
    task automatic press_bit(input logic b);
        @(negedge clk);
        bus.bit_in = b;
        repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.key_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) press_bit(f[i]);
    endtask

    // Minimum-spacing press: key low for one edge, high for the next.
    task automatic fast_press();
        bus.key_in = 1'b0;
        @(negedge clk);
        bus.key_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_upc"},     32'(bus.upc),     32'd0);
        check({tag, "_mark"},    32'(bus.mark),    32'd0);
        check({tag, "_valid"},   32'(bus.valid),   32'd0);
        check({tag, "_load"},    32'(bus.load),    32'd0);
        check({tag, "_err"},     32'(bus.err),     32'd0);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
        check({tag, "_bit_cnt"}, 32'(bus.bit_cnt), 32'd0);
    endtask

    initial begin
        int l0, e0;

        vecs[0] = '{4'b1000, 3'b110, 1'b1, 1'b1, 0, 1};
        vecs[1] = '{4'b0000, 3'b000, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{4'b0011, 3'b001, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{4'b0100, 3'b010, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{4'b1010, 3'b101, 1'b0, 1'b1, 1, 0};
        vecs[5] = '{4'b1111, 3'b111, 1'b1, 1'b1, 1, 0};
        vecs[6] = '{4'b0111, 3'b111, 1'b1, 1'b1, 0, 1};
        vecs[7] = '{4'b0110, 3'b111, 1'b1, 1'b1, 0, 1};
        vecs[8] = '{4'b1100, 3'b110, 1'b0, 1'b1, 1, 0};

        // Key held low through reset: no press after release.
        bus.key_in = 1'b0;
        bus.bit_in = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("held_thru_reset_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check("held_thru_reset_busy",    32'(bus.busy),    32'd0);
        bus.key_in = 1'b1;
        repeat (4) @(negedge clk);
        check("key_release_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        $display("[TB] held-key-through-reset bit_cnt=%0d", bus.bit_cnt);

        do_reset();
        check_reset_vals("after_reset");
        $display("[TB] reset upc=%b mark=%b valid=%b", bus.upc, bus.mark, bus.valid);

        // Valid frame 1,1,0,1 with exact completion latency.
        press_bit(1'b1);
        press_bit(1'b1);
        press_bit(1'b0);
        check("mid_bit_cnt", 32'(bus.bit_cnt), 32'd3);
        check("mid_busy",    32'(bus.busy),    32'd1);
        check("mid_upc",     32'(bus.upc),     32'd0);
        check("mid_valid",   32'(bus.valid),   32'd0);
        l0 = load_cycles;
        @(negedge clk);
        bus.bit_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_n2_load", 32'(bus.load), 32'd0);
        @(negedge clk);
        check("lat_n3_load",    32'(bus.load),    32'd1);
        check("lat_n3_upc",     32'(bus.upc),     32'd6);
        check("lat_n3_mark",    32'(bus.mark),    32'd1);
        check("lat_n3_valid",   32'(bus.valid),   32'd1);
        check("lat_n3_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        bus.key_in = 1'b1;
        @(negedge clk);
        check("lat_n4_load", 32'(bus.load), 32'd0);
        repeat (2) @(negedge clk);
        check("lat_load_count", 32'(load_cycles - l0), 32'd1);
        $display("[TB] frame 1101 upc=%b mark=%b valid=%b", bus.upc, bus.mark, bus.valid);

        // Table of frames, each starting from the previous frame's state.
        for (int v = 0; v < 9; v++) begin
            l0 = load_cycles;
            e0 = err_cycles;
            send_frame(vecs[v].bits);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_loads", v), 32'(load_cycles - l0), 32'(vecs[v].exp_loads));
            check($sformatf("vec%0d_errs", v),  32'(err_cycles - e0),  32'(vecs[v].exp_errs));
            check($sformatf("vec%0d_upc", v),   32'(bus.upc),   32'(vecs[v].exp_upc));
            check($sformatf("vec%0d_mark", v),  32'(bus.mark),  32'(vecs[v].exp_mark));
            check($sformatf("vec%0d_valid", v), 32'(bus.valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_bit_cnt", v), 32'(bus.bit_cnt), 32'd0);
            $display("[TB] vec%0d bits=%b upc=%b mark=%b loads=%0d errs=%0d",
                     v, vecs[v].bits, bus.upc, bus.mark, load_cycles - l0, err_cycles - e0);
        end

        // Reset mid-frame.
        press_bit(1'b1);
        press_bit(1'b0);
        check("midrst_bit_cnt_before", 32'(bus.bit_cnt), 32'd2);
        check("midrst_busy_before",    32'(bus.busy),    32'd1);
        do_reset();
        check_reset_vals("midrst");
        send_frame(4'b0010);
        repeat (2) @(negedge clk);
        check("midrst_next_upc",   32'(bus.upc),   32'd1);
        check("midrst_next_mark",  32'(bus.mark),  32'd0);
        check("midrst_next_valid", 32'(bus.valid), 32'd1);
        $display("[TB] reset mid-frame then 0010 upc=%b mark=%b", bus.upc, bus.mark);

        // Held key counts once.
        do_reset();
        bus.bit_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        repeat (100) @(negedge clk);
        check("held_bit_cnt", 32'(bus.bit_cnt), 32'd1);
        bus.key_in = 1'b1;
        repeat (4) @(negedge clk);
        check("held_release_bit_cnt", 32'(bus.bit_cnt), 32'd1);
        $display("[TB] held key 100 cycles bit_cnt=%0d", bus.bit_cnt);

        // Back-to-back frames 0000 then 1111 at minimum spacing.
        do_reset();
        l0 = load_cycles;
        e0 = err_cycles;
        bus.bit_in = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) fast_press();
        repeat (2) @(negedge clk);
        check("b2b_first_valid", 32'(bus.valid), 32'd1);
        check("b2b_first_upc",   32'(bus.upc),   32'd0);
        bus.bit_in = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) fast_press();
        repeat (6) @(negedge clk);
        check("b2b_loads", 32'(load_cycles - l0), 32'd2);
        check("b2b_errs",  32'(err_cycles - e0),  32'd0);
        check("b2b_upc",   32'(bus.upc),  32'd7);
        check("b2b_mark",  32'(bus.mark), 32'd1);
        $display("[TB] back-to-back loads=%0d upc=%b mark=%b", load_cycles - l0, bus.upc, bus.mark);

`ifdef UPC_ENTRY_TIMEOUT_EN
        // One press, then idle: expiry 16 cycles after the capture edge.
        do_reset();
        e0 = err_cycles;
        bus.bit_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 3) bus.key_in = 1'b1;
            if (k == 4)  check("to_bit_cnt_1", 32'(bus.bit_cnt), 32'd1);
            if (k == 19) check("to_before_err", 32'(bus.err), 32'd0);
            if (k == 20) begin
                check("to_err",     32'(bus.err),     32'd1);
                check("to_bit_cnt", 32'(bus.bit_cnt), 32'd0);
                check("to_busy",    32'(bus.busy),    32'd0);
            end
            if (k == 21) check("to_err_deassert", 32'(bus.err), 32'd0);
        end
        check("to_err_count", 32'(err_cycles - e0), 32'd1);
        $display("[TB] timeout err pulses=%0d bit_cnt=%0d", err_cycles - e0, bus.bit_cnt);

        // Second press lands on the expiry cycle: press wins.
        do_reset();
        e0 = err_cycles;
        bus.bit_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.key_in = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 3)  bus.key_in = 1'b1;
            if (k == 14) bus.bit_in = 1'b0;
            if (k == 16) bus.key_in = 1'b0;
            if (k == 19) bus.key_in = 1'b1;
            if (k == 20) begin
                check("race_err",     32'(bus.err),     32'd0);
                check("race_bit_cnt", 32'(bus.bit_cnt), 32'd2);
                check("race_busy",    32'(bus.busy),    32'd1);
            end
        end
        check("race_err_count", 32'(err_cycles - e0), 32'd0);
        $display("[TB] timeout race bit_cnt=%0d errs=%0d", bus.bit_cnt, err_cycles - e0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
